grey_decode: RTL

GREY_DECODE -- requirements
Module: grey_decode

---
 rtl/grey_decode_if.sv | 13 +
 rtl/grey_decode.sv | 94 +++++++++
 2 files changed

// File: rtl/grey_decode_if.sv
// grey_decode_if: request/result bundle between a requester and the Grey digit decoder.
interface grey_decode_if;
  logic        i_start;
  logic [44:0] i_digits;
  logic        o_busy;
  logic        o_done;
  logic [29:0] o_value;
  logic [35:0] o_bcd;
  logic        o_err;
  logic [3:0]  o_err_pos;
  modport master (output i_start, i_digits, input o_busy, o_done, o_value, o_bcd, o_err, o_err_pos);
  modport slave  (input i_start, i_digits, output o_busy, o_done, o_value, o_bcd, o_err, o_err_pos);
endinterface

// File: rtl/grey_decode.sv
// grey_decode: serial nine-digit Grey-to-binary/BCD converter, one digit per cycle, MS digit first.
module grey_decode (
  input  logic i_clk,
  input  logic i_rst,
  grey_decode_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t      state, state_n;
  logic [44:0] digits_q;
  logic [29:0] acc;
  logic [35:0] bcd;
  logic [3:0]  idx;
  logic        err;
  logic [3:0]  err_pos;
  logic [29:0] value_q;
  logic [35:0] bcd_q;
  logic        done_q, err_q;
  logic [3:0]  pos_q;
  logic [4:0]  code;
  logic [3:0]  val;
  logic        ok;
  // The latched word shifts left each cycle, so the digit being decoded is always the top field.
  assign code = digits_q[44:40];
  always_comb begin
    val = 4'd0;
    ok  = 1'b1;
    case (code)
      5'b00000: val = 4'd0;
      5'b00001: val = 4'd1;
      5'b00011: val = 4'd2;
      5'b00010: val = 4'd3;
      5'b00110: val = 4'd4;
      5'b00100: val = 4'd5;
      5'b01100: val = 4'd6;
      5'b01000: val = 4'd7;
      5'b11000: val = 4'd8;
      5'b10000: val = 4'd9;
      default:  ok  = 1'b0;
    endcase
  end
  always_ff @(posedge i_clk)
    if (i_rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? (bus.i_start ? CONV : IDLE) :
              state == CONV ? (idx == 4'd0 ? DONE : CONV) : IDLE;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      digits_q <= '0;
      acc      <= '0;
      bcd      <= '0;
      idx      <= '0;
      err      <= 1'b0;
      err_pos  <= '0;
      value_q  <= '0;
      bcd_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pos_q    <= '0;
    end else begin
      done_q <= state == DONE;
      if (state == IDLE && bus.i_start) begin
        digits_q <= bus.i_digits;
        acc      <= '0;
        bcd      <= '0;
        idx      <= 4'd8;
        err      <= 1'b0;
        err_pos  <= '0;
      end else if (state == CONV) begin
        digits_q <= {digits_q[39:0], 5'b0};
        acc      <= acc * 30'd10 + 30'(val);
        bcd      <= {bcd[31:0], val};
        idx      <= idx - 4'd1;
        if (!ok && !err) begin
          err     <= 1'b1;
          err_pos <= idx;
        end
      end
      if (state == DONE) begin
        value_q <= acc;
        bcd_q   <= bcd;
        err_q   <= err;
        pos_q   <= err_pos;
      end
    end
  assign bus.o_busy    = state != IDLE;
  assign bus.o_done    = done_q;
  assign bus.o_value   = value_q;
  assign bus.o_bcd     = bcd_q;
  assign bus.o_err     = err_q;
  assign bus.o_err_pos = pos_q;
endmodule
